df_tile_ptr_gen: RTL

//  Parametrised tile-loop sequencer for the dataflow controller. It walks the 4-level tile nest (x, y, k, c).
//  Per tile it emits one descriptor over valid/ready: psums, ifmaps and weights base pointers plus
//  c-accumulation flags. Pointers are computed incrementally (adders only); loop order is selectable at runtime.

---
 rtl/df_ctrl_pkg.sv | 34 +++
 rtl/df_ptr_level_acc.sv | 36 +++
 rtl/df_tile_ptr_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/df_ctrl_pkg.sv
// Shared dataflow-controller types: loop order, tile pointer generator states,
// and the mapping from loop-nest level (0 = innermost) to tile dimension.
package df_ctrl_pkg;

  typedef enum logic {LOOP_C_INNER, LOOP_X_INNER} LoopOrder;

  typedef enum logic [1:0] {TPG_IDLE, TPG_EMIT, TPG_DONE} TilePtrGenState;

  typedef enum logic [1:0] {DIM_X, DIM_Y, DIM_K, DIM_C} LoopDim;

  localparam int NUM_LVL = 4;

  // k is always outermost; the order bit only reshuffles the three inner levels.
  function automatic LoopDim dim_at_level(LoopOrder ord, logic [1:0] lvl);
    LoopDim d;
    if (ord == LOOP_C_INNER) begin
      case (lvl)
        2'd0:    d = DIM_C;
        2'd1:    d = DIM_X;
        2'd2:    d = DIM_Y;
        default: d = DIM_K;
      endcase
    end else begin
      case (lvl)
        2'd0:    d = DIM_X;
        2'd1:    d = DIM_Y;
        2'd2:    d = DIM_C;
        default: d = DIM_K;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/df_ptr_level_acc.sv
// Per-operand level-pointer stack: one register per loop level, loaded with the
// base on start and advanced incrementally; the innermost register is the tile pointer.
module df_ptr_level_acc
  import df_ctrl_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             load,
  input  logic [ADDR_W-1:0]                base,
  input  logic                             adv,
  input  logic [1:0]                       adv_lvl,
  input  logic [NUM_LVL-1:0][ADDR_W-1:0]   step,
  output logic [ADDR_W-1:0]                ptr
);

  logic [NUM_LVL-1:0][ADDR_W-1:0] p;
  logic [ADDR_W-1:0]              nxt;

  assign nxt = p[adv_lvl] + step[adv_lvl];
  assign ptr = p[0];

  // Advancing level L reloads every inner level with the new p[L].
  always_ff @(posedge clk) begin
    if (!rstn) begin
      p <= '0;
    end else if (load) begin
      p <= {NUM_LVL{base}};
    end else if (adv) begin
      for (int l = 0; l < NUM_LVL; l++)
        if (2'(l) <= adv_lvl) p[l] <= nxt;
    end
  end

endmodule

// File: rtl/df_tile_ptr_gen.sv
// Tile-loop sequencer: walks the x/y/k/c tile nest and emits one pointer descriptor
// per tile over valid/ready. Optional stall counter under DF_TILE_PTR_PERF_EN.
module df_tile_ptr_gen
  import df_ctrl_pkg::*;
#(
  parameter int IDX_W  = 12,
  parameter int ADDR_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_loop_order,
  input  logic [IDX_W-1:0]  i_x_lim,
  input  logic [IDX_W-1:0]  i_y_lim,
  input  logic [IDX_W-1:0]  i_k_lim,
  input  logic [IDX_W-1:0]  i_c_lim,
  input  logic [ADDR_W-1:0] i_psums_base,
  input  logic [ADDR_W-1:0] i_ifmaps_base,
  input  logic [ADDR_W-1:0] i_weights_base,
  input  logic [ADDR_W-1:0] i_psums_x_step,
  input  logic [ADDR_W-1:0] i_psums_y_step,
  input  logic [ADDR_W-1:0] i_psums_k_step,
  input  logic [ADDR_W-1:0] i_ifmaps_x_step,
  input  logic [ADDR_W-1:0] i_ifmaps_y_step,
  input  logic [ADDR_W-1:0] i_ifmaps_c_step,
  input  logic [ADDR_W-1:0] i_weights_k_step,
  input  logic [ADDR_W-1:0] i_weights_c_step,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tile_valid,
  input  logic              i_tile_ready,
  output logic [ADDR_W-1:0] o_psums_ptr,
  output logic [ADDR_W-1:0] o_ifmaps_ptr,
  output logic [ADDR_W-1:0] o_weights_ptr,
  output logic              o_first_c,
  output logic              o_last_c,
  output logic              o_last
`ifdef DF_TILE_PTR_PERF_EN
  , output logic [31:0]     o_stall_cnt
`endif
);

  TilePtrGenState state;
  LoopOrder       ord_in;

  logic [NUM_LVL-1:0][IDX_W-1:0]  lvl_idx, lvl_lim, lim_in;
  logic [NUM_LVL-1:0][ADDR_W-1:0] ps_step, if_step, wt_step;
  logic [NUM_LVL-1:0][ADDR_W-1:0] ps_step_in, if_step_in, wt_step_in;
  logic [1:0]                     c_lvl, c_lvl_in, adv_lvl;
  logic [NUM_LVL-1:0]             at_lim;
  logic                           all_last, hs, adv, load;

  assign ord_in = LoopOrder'(i_loop_order);
  assign load   = (state == TPG_IDLE) && i_start;
  assign hs     = o_tile_valid && i_tile_ready;
  assign adv    = hs && !all_last;

  // Re-index the per-dimension config by loop level; an operand lacking a dim steps by 0.
  always_comb begin
    lim_in     = '0;
    ps_step_in = '0;
    if_step_in = '0;
    wt_step_in = '0;
    c_lvl_in   = '0;
    for (int l = 0; l < NUM_LVL; l++) begin
      case (dim_at_level(ord_in, 2'(l)))
        DIM_X: begin
          lim_in[l]     = i_x_lim;
          ps_step_in[l] = i_psums_x_step;
          if_step_in[l] = i_ifmaps_x_step;
        end
        DIM_Y: begin
          lim_in[l]     = i_y_lim;
          ps_step_in[l] = i_psums_y_step;
          if_step_in[l] = i_ifmaps_y_step;
        end
        DIM_K: begin
          lim_in[l]     = i_k_lim;
          ps_step_in[l] = i_psums_k_step;
          wt_step_in[l] = i_weights_k_step;
        end
        default: begin
          lim_in[l]     = i_c_lim;
          if_step_in[l] = i_ifmaps_c_step;
          wt_step_in[l] = i_weights_c_step;
          c_lvl_in      = 2'(l);
        end
      endcase
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LVL; l++)
      at_lim[l] = (lvl_idx[l] == lvl_lim[l]);
  end

  assign all_last = &at_lim;

  // Innermost level that still has iterations left.
  always_comb begin
    adv_lvl = '0;
    for (int l = NUM_LVL - 1; l >= 0; l--)
      if (!at_lim[l]) adv_lvl = 2'(l);
  end

  assign o_first_c = o_tile_valid && (lvl_idx[c_lvl] == '0);
  assign o_last_c  = o_tile_valid && at_lim[c_lvl];
  assign o_last    = o_tile_valid && all_last;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= TPG_IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_tile_valid <= 1'b0;
      lvl_idx      <= '0;
      lvl_lim      <= '0;
      ps_step      <= '0;
      if_step      <= '0;
      wt_step      <= '0;
      c_lvl        <= '0;
    end else begin
      case (state)
        TPG_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state        <= TPG_EMIT;
            o_busy       <= 1'b1;
            o_tile_valid <= 1'b1;
            lvl_idx      <= '0;
            lvl_lim      <= lim_in;
            ps_step      <= ps_step_in;
            if_step      <= if_step_in;
            wt_step      <= wt_step_in;
            c_lvl        <= c_lvl_in;
          end
        end
        TPG_EMIT: begin
          if (hs) begin
            if (all_last) begin
              state        <= TPG_DONE;
              o_tile_valid <= 1'b0;
              o_done       <= 1'b1;
            end else begin
              for (int l = 0; l < NUM_LVL; l++) begin
                if (2'(l) < adv_lvl)       lvl_idx[l] <= '0;
                else if (2'(l) == adv_lvl) lvl_idx[l] <= lvl_idx[l] + 1'b1;
              end
            end
          end
        end
        TPG_DONE: begin
          state  <= TPG_IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: begin
          state        <= TPG_IDLE;
          o_busy       <= 1'b0;
          o_done       <= 1'b0;
          o_tile_valid <= 1'b0;
        end
      endcase
    end
  end

  df_ptr_level_acc #(.ADDR_W(ADDR_W)) u_psums_acc (
    .clk(i_clk), .rstn(i_rstn), .load(load), .base(i_psums_base),
    .adv(adv), .adv_lvl(adv_lvl), .step(ps_step), .ptr(o_psums_ptr)
  );

  df_ptr_level_acc #(.ADDR_W(ADDR_W)) u_ifmaps_acc (
    .clk(i_clk), .rstn(i_rstn), .load(load), .base(i_ifmaps_base),
    .adv(adv), .adv_lvl(adv_lvl), .step(if_step), .ptr(o_ifmaps_ptr)
  );

  df_ptr_level_acc #(.ADDR_W(ADDR_W)) u_weights_acc (
    .clk(i_clk), .rstn(i_rstn), .load(load), .base(i_weights_base),
    .adv(adv), .adv_lvl(adv_lvl), .step(wt_step), .ptr(o_weights_ptr)
  );

`ifdef DF_TILE_PTR_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      o_stall_cnt <= '0;
    else if (load)
      o_stall_cnt <= '0;
    else if (o_tile_valid && !i_tile_ready && (o_stall_cnt != 32'hFFFF_FFFF))
      o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule
